// File: rtl/mux1hot_rr_arbiter8_pkg.sv
// Shared definitions for the 8-requester round-robin burst arbiter.
// Contents: FSM state encoding, requester count, and the helpers that
// pick a round-robin winner, encode a one-hot grant and check grant shape.
package mux1hot_rr_arbiter8_pkg;

    localparam int NREQ = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // First set bit of req at or above ptr, wrapping 7->0; one-hot result.
    function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [7:0] win;
        logic [2:0] idx;
        logic       found;
        win   = 8'h00;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + 3'(i);
            if (req[idx] && !found) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return win;
    endfunction

    // Index of the set bit of a one-hot vector (0 for an all-zero vector).
    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

    // True when the vector is one-hot or all-zero.
    function automatic logic is_onehot0(input logic [7:0] v);
        return ((v & (v - 8'd1)) == 8'h00);
    endfunction

endpackage

// File: rtl/mux1hot_rr_arbiter8_mux.sv
// 8:1 one-hot multiplexer with default value.
// Ports: sel (one-hot select), in0..in7 (data inputs), dflt (value when
// sel is zero or not one-hot), dout (selected data).
module mux1hot_with_default8 #(
    parameter int WIDTH = 1
) (
    input  logic [7:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic [WIDTH-1:0] dflt,
    output logic [WIDTH-1:0] dout
);

    // Select path; any non-one-hot select falls back to the default value.
    always_comb begin
        dout = dflt;
        case (sel)
            8'h01:   dout = in0;
            8'h02:   dout = in1;
            8'h04:   dout = in2;
            8'h08:   dout = in3;
            8'h10:   dout = in4;
            8'h20:   dout = in5;
            8'h40:   dout = in6;
            8'h80:   dout = in7;
            default: dout = dflt;
        endcase
    end

endmodule

// File: rtl/mux1hot_rr_arbiter8.sv
// Round-robin burst arbiter sharing one 8:1 one-hot mux between 8 requesters.
// A requester keeps the grant for a whole valid/ready burst ended by last;
// one idle cycle separates bursts.
// Optional feature macro: ARB_LOCK_EN adds req_lock[7:0]; a locked last beat
// keeps the grant so the same requester continues without a bubble.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/last/data per-requester beat (data flattened, WIDTH per port)
//   req_lock            per-requester lock (ARB_LOCK_EN only)
//   req_ready           grant & out_ready
//   dflt                out_data value when nothing is granted
//   out_valid/data/last selected beat towards the consumer
//   out_ready           consumer accepts the beat
//   grant               registered one-hot grant (mux select)
//   busy                high while a burst is granted
module mux1hot_rr_arbiter8
    import mux1hot_rr_arbiter8_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         req_valid,
    input  logic [7:0]         req_last,
    input  logic [8*WIDTH-1:0] req_data,
`ifdef ARB_LOCK_EN
    input  logic [7:0]         req_lock,
`endif
    output logic [7:0]         req_ready,
    input  logic [WIDTH-1:0]   dflt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic [7:0]         grant,
    output logic               busy
);

    state_t           state_r;
    state_t           state_nx_s;
    logic [7:0]       grant_r;
    logic [7:0]       grant_nx_s;
    logic [2:0]       rr_ptr_r;
    logic [2:0]       rr_ptr_nx_s;
    logic             accept_s;
    logic             lock_hit_s;
    logic             shape_ok_s;
    logic             out_valid_s;
    logic             out_last_s;
    logic [7:0]       req_ready_s;
    logic             busy_s;
    logic [WIDTH-1:0] out_data_s;

    mux1hot_with_default8 #(.WIDTH(WIDTH)) u_data_mux (
        .sel  (grant_r),
        .in0  (req_data[0*WIDTH +: WIDTH]),
        .in1  (req_data[1*WIDTH +: WIDTH]),
        .in2  (req_data[2*WIDTH +: WIDTH]),
        .in3  (req_data[3*WIDTH +: WIDTH]),
        .in4  (req_data[4*WIDTH +: WIDTH]),
        .in5  (req_data[5*WIDTH +: WIDTH]),
        .in6  (req_data[6*WIDTH +: WIDTH]),
        .in7  (req_data[7*WIDTH +: WIDTH]),
        .dflt (dflt),
        .dout (out_data_s)
    );

    mux1hot_with_default8 #(.WIDTH(1)) u_last_mux (
        .sel  (grant_r),
        .in0  (req_last[0]),
        .in1  (req_last[1]),
        .in2  (req_last[2]),
        .in3  (req_last[3]),
        .in4  (req_last[4]),
        .in5  (req_last[5]),
        .in6  (req_last[6]),
        .in7  (req_last[7]),
        .dflt (1'b0),
        .dout (out_last_s)
    );

    // Lock qualifier: only the granted requester's lock can hold the grant.
    always_comb begin
`ifdef ARB_LOCK_EN
        lock_hit_s = |(grant_r & req_lock);
`else
        lock_hit_s = 1'b0;
`endif
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            grant_r  <= 8'h00;
            rr_ptr_r <= 3'd0;
        end else begin
            state_r  <= state_nx_s;
            grant_r  <= grant_nx_s;
            rr_ptr_r <= rr_ptr_nx_s;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant until the last beat.
    always_comb begin
        state_nx_s  = state_r;
        grant_nx_s  = grant_r;
        rr_ptr_nx_s = rr_ptr_r;
        accept_s    = out_valid_s & out_ready;
        // BUSY must carry exactly one grant bit and IDLE none; anything else
        // can only come from an upset and is recovered by returning to IDLE.
        shape_ok_s  = is_onehot0(grant_r) &&
                      ((state_r == ST_BUSY) == (grant_r != 8'h00));
        if (!shape_ok_s) begin
            state_nx_s = ST_IDLE;
            grant_nx_s = 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant_nx_s = rr_pick(req_valid, rr_ptr_r);
                        state_nx_s = ST_BUSY;
                    end else begin
                        grant_nx_s = 8'h00;
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (accept_s && out_last_s && !lock_hit_s) begin
                        grant_nx_s  = 8'h00;
                        state_nx_s  = ST_IDLE;
                        rr_ptr_nx_s = onehot_idx(grant_r) + 3'd1;
                    end else begin
                        grant_nx_s = grant_r;
                        state_nx_s = ST_BUSY;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    grant_nx_s = 8'h00;
                end
            endcase
        end
    end

    // Outputs derived from the registered grant and state.
    always_comb begin
        out_valid_s = |(grant_r & req_valid);
        req_ready_s = grant_r & {8{out_ready}};
        busy_s      = (state_r == ST_BUSY);
    end

    assign grant     = grant_r;
    assign busy      = busy_s;
    assign out_valid = out_valid_s;
    assign out_data  = out_data_s;
    assign out_last  = out_last_s;
    assign req_ready = req_ready_s;

endmodule

// File: tb/tb_mux1hot_rr_arbiter8.sv
// Self-checking bench for mux1hot_rr_arbiter8 (WIDTH=4). Expected beats are
// queued when driven and compared when the DUT accepts them.
module tb_mux1hot_rr_arbiter8;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [7:0]     req_valid;
    logic [7:0]     req_last;
    logic [8*W-1:0] req_data;
`ifdef ARB_LOCK_EN
    logic [7:0]     req_lock;
`endif
    logic [7:0]     req_ready;
    logic [W-1:0]   dflt;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic [7:0]     grant;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [4:0] sb_q[$];   // {last, data}

    always #5 clk = ~clk;

    mux1hot_rr_arbiter8 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
`ifdef ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .dflt      (dflt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_data(input int port, input logic [W-1:0] v);
        req_data[port*W +: W] = v;
    endtask

    task automatic sb_push(input logic last, input logic [W-1:0] d);
        sb_q.push_back({last, d});
    endtask

    // Compare the beat currently on the output against the oldest expected one.
    task automatic sb_pop(input string tag);
        logic [4:0] e;
        check({tag, "_acc"}, {31'd0, out_valid & out_ready}, 32'd1);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_sb: observed empty queue expected a beat", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_data"}, {28'd0, out_data}, {28'd0, e[3:0]});
            check({tag, "_last"}, {31'd0, out_last}, {31'd0, e[4]});
        end
    endtask

    initial begin
        int k;
        logic [4:0] pat;

        // 1. Reset with all requesters active.
        rst_n = 1'b0; req_valid = 8'hFF; req_last = 8'hFF;
        req_data = 32'h7654_3210; dflt = 4'hA; out_ready = 1'b1;
`ifdef ARB_LOCK_EN
        req_lock = 8'h00;
`endif
        advance();
        advance();
        settle();
        check("rst_grant", {24'd0, grant}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {28'd0, out_data}, 32'hA);
        check("rst_ready", {24'd0, req_ready}, 32'h00);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        advance();
        rst_n = 1'b1; req_valid = 8'h00; req_last = 8'h00;
        advance();

        // 2. Single request from port 2, then rr_ptr=3 seen via ports 0/3.
        req_valid = 8'h04; req_last = 8'h04; set_data(2, 4'h5);
        sb_push(1'b1, 4'h5);
        settle();
        check("t2_pre_grant", {24'd0, grant}, 32'h00);
        advance();
        settle();
        check("t2_grant", {24'd0, grant}, 32'h04);
        check("t2_busy", {31'd0, busy}, 32'd1);
        check("t2_ready", {24'd0, req_ready}, 32'h04);
        sb_pop("t2_beat");
        advance();
        req_valid = 8'h00;
        settle();
        check("t2_idle_grant", {24'd0, grant}, 32'h00);
        check("t2_idle_busy", {31'd0, busy}, 32'd0);
        check("t2_idle_data", {28'd0, out_data}, 32'hA);
        req_valid = 8'h09; req_last = 8'h09; set_data(0, 4'h1); set_data(3, 4'h3);
        sb_push(1'b1, 4'h3);
        advance();
        settle();
        check("t2_ptr3_grant", {24'd0, grant}, 32'h08);
        sb_pop("t2_ptr3_beat");
        req_valid = 8'h00;
        advance();

        // 3. Rotation from a fresh pointer with all requesting.
        rst_n = 1'b0; req_valid = 8'hFF; req_last = 8'hFF;
        for (int i = 0; i < 8; i++) set_data(i, 4'(i + 1));
        advance();
        rst_n = 1'b1;
        for (int g = 0; g < 9; g++) begin
            sb_push(1'b1, 4'((g % 8) + 1));
            advance();
            settle();
            check($sformatf("rot_grant%0d", g), {24'd0, grant}, 32'(8'h01 << (g % 8)));
            sb_pop($sformatf("rot_beat%0d", g));
            advance();
            settle();
            check($sformatf("rot_bubble%0d", g), {24'd0, grant}, 32'h00);
            check($sformatf("rot_bdata%0d", g), {28'd0, out_data}, 32'hA);
        end
        req_valid = 8'h00;
        advance();

        // 4. Backpressure on a 3-beat burst from port 5 (pointer now 1).
        req_valid = 8'h20; req_last = 8'h00; set_data(5, 4'h7);
        advance();
        settle();
        check("bp_grant0", {24'd0, grant}, 32'h20);
        advance();
        req_valid = 8'h22; set_data(1, 4'hB);
        pat = 5'b10101;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            out_ready = pat[c];
            set_data(5, 4'(7 + k));
            req_last[5] = (k == 2);
            if (pat[c]) sb_push(k == 2, 4'(7 + k));
            settle();
            check($sformatf("bp_grant_c%0d", c), {24'd0, grant}, 32'h20);
            check($sformatf("bp_ready_c%0d", c), {24'd0, req_ready}, pat[c] ? 32'h20 : 32'h00);
            if (pat[c]) begin
                sb_pop($sformatf("bp_beat%0d", k));
                k++;
            end
            advance();
        end
        out_ready = 1'b1;
        req_valid = 8'h02; req_last = 8'h00;
        settle();
        check("bp_bubble_busy", {31'd0, busy}, 32'd0);
        advance();
        settle();
        check("bp_next_grant", {24'd0, grant}, 32'h02);

        // 5. Reset during beat 2 of port 1's burst.
        sb_push(1'b0, 4'hB);
        sb_pop("mr_beat1");
        advance();
        set_data(1, 4'hC); rst_n = 1'b0;
        advance();
        rst_n = 1'b1; req_valid = 8'h81; req_last = 8'h81;
        set_data(0, 4'h1); set_data(7, 4'hE);
        settle();
        check("mr_grant", {24'd0, grant}, 32'h00);
        check("mr_busy", {31'd0, busy}, 32'd0);
        sb_push(1'b1, 4'h1);
        advance();
        settle();
        check("mr_fresh_grant", {24'd0, grant}, 32'h01);
        sb_pop("mr_fresh_beat");
        req_valid = 8'h00; req_last = 8'h00;
        advance();
        advance();

`ifdef ARB_LOCK_EN
        // 6. Locked back-to-back bursts from port 2, then port 3.
        req_valid = 8'h04; req_last = 8'h04; req_lock = 8'h04; set_data(2, 4'h3);
        sb_push(1'b1, 4'h3);
        advance();
        settle();
        check("lk_grant1", {24'd0, grant}, 32'h04);
        sb_pop("lk_beat1");
        advance();
        req_valid = 8'h0C; req_last = 8'h0C; req_lock = 8'h00;
        set_data(2, 4'h4); set_data(3, 4'h9);
        sb_push(1'b1, 4'h4);
        settle();
        check("lk_nobubble_grant", {24'd0, grant}, 32'h04);
        check("lk_nobubble_busy", {31'd0, busy}, 32'd1);
        sb_pop("lk_beat2");
        advance();
        settle();
        check("lk_release", {24'd0, grant}, 32'h00);
        sb_push(1'b1, 4'h9);
        advance();
        settle();
        check("lk_port3", {24'd0, grant}, 32'h08);
        sb_pop("lk_beat3");
        req_valid = 8'h00;
        advance();
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
